cpu_decode_queue: RTL and testbench
===================================

# cpu_decode_queue

Parametrised RV32I decode stage with a DEPTH-entry decoded-instruction queue between fetch and execute. It replaces the single-register decode stage. Fetch and decode are decoupled, so fetch keeps running while execute stalls. The block decodes each instruction once, on entry to the queue, and adds illegal-opcode detection and a pipeline flush. The tag handshake is kept on both sides: a new input tag means a new instruction, and a new output tag means a new decoded instruction.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- TAG_W, 3, tag width
- i_clock  in  1  clock
- i_reset  in  1  reset; asynchronous, active-high
- i_tag  in  TAG_W  fetch tag; differs from the last accepted tag when a new instruction is offered
- i_instruction  in  32  raw instruction
- i_pc  in  32  instruction PC
- i_flush  in  1  discard queue and pending input
- i_stall  in  1  downstream cannot take a new output
- o_busy  out  1  queue full; upstream must hold
- o_tag  out  TAG_W  tag of the presented instruction
- o_instruction, o_pc  out  32 each  presented instruction and PC
- o_inst_rs1, o_inst_rs2, o_inst_rd  out  5 each  register indices; 0 when the format has no such field
- o_imm  out  32  format-selected immediate
- o_branch  out  1  BRANCH, JAL or JALR
- o_illegal  out  1  unrecognised encoding
- o_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- **Decode (combinational, on input).** Any instruction with inst[1:0]≠2'b11 is illegal. For legal instructions, opcode inst[6:0] selects the format:
  - I: 0000011, 0010011, 1100111, 0001111, 1110011
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011
  - Any other opcode is illegal.
- **Register fields.** rs1 = inst[19:15] for B/I/R/S. rs2 = inst[24:20] for B/R/S. rd = inst[11:7] for I/J/R/U. Absent fields are 0.
- **Immediates.** Standard RV32I sign-extended I/S/B/J immediates; U = {inst[31:12], 12'b0}; R = 0.
- **Illegal entries.** Fields and immediate are 0. o_illegal=1, and instruction and PC are still carried.
- **Push.** At an edge with i_tag≠last_tag, !full and !i_flush, the decoded entry plus i_tag is written at the write pointer, and last_tag←i_tag.
- **Pop.** At an edge with !i_stall, count>0 and !i_flush, the head entry is loaded into the output registers (o_tag←entry tag) and the read pointer advances.
- **Push and pop in the same edge** are both allowed; count is unchanged.
- **Full.** The full check uses the pre-edge count. A push offered while full waits, because its tag stays unaccepted.
- **Pointers.** $clog2(DEPTH) bits, wrapping naturally. count = wr−rd, tracked in a separate counter 0..DEPTH.
- **Flush** has priority over push and pop:
  - count, wr and rd ←0
  - last_tag←i_tag, so the instruction currently offered is dropped
  - output registers and o_tag hold
- **Output side.** Downstream detects new work only by an o_tag change. Two consecutive entries always carry different tags.

## Timing
- **Reset** (asynchronous, any cycle): every output is 0 and o_busy=0; internally last_tag=0, count=0, pointers=0. A fetch tag of 0 after reset is therefore not accepted.
- **o_busy** = (count==DEPTH). It is combinational from registered count, with no input-to-output combinational path.
- **Latency on an empty queue with i_stall=0:** accepted at edge N, presented after edge N+1. There is no bypass.
- **Throughput:** one instruction per cycle when fetch offers a new tag every cycle and i_stall=0.
- **i_stall** only blocks pop. Pushes continue until the queue is full.
- **Reset mid-operation:** queue contents are lost and outputs return to 0 immediately, without waiting for a clock edge.

## Test plan
- **Single decodes** (DEPTH=4, no stall, new tag per instruction):
  - 0xFFF10093 → rs1=2, rs2=0, rd=1, imm=0xFFFFFFFF, branch=0, illegal=0
  - 0x00208463 → rs1=1, rs2=2, rd=0, imm=0x00000008, branch=1
  - 0x123452B7 → rd=5, imm=0x12345000
  - All three appear 2 edges after their tag changes.
- **Illegal encodings:** 0x00000000 and 0x0000007F → o_illegal=1, rs1/rs2/rd/imm=0, o_pc carried.
- **Fill and drain:** hold i_stall=1 and offer tags 1,2,3,4,5.
  - After 4 accepts: o_busy=1, o_count=4, and tag 5 is not accepted.
  - Release stall: tags 1,2,3,4,5 emerge in order, one per cycle, and o_busy falls after the first pop.
- **Repeated tag:** hold i_tag=3 for 5 cycles → exactly one entry pushed and o_count peaks at 1.
- **Flush:** with count=3 and a new tag offered, pulse i_flush → count=0, the offered tag is dropped and o_tag holds. The next distinct tag is accepted and presented 2 edges later.
- **Asynchronous reset:** assert i_reset mid-cycle while count=2 → o_tag=0, o_count=0 and o_busy=0 before the next clock edge. Following pointer wrap-around, 2×DEPTH pushes and pops keep FIFO order.

Source files
------------

// File: rtl/cpu_decode_queue.sv
// RV32I decode stage with a DEPTH-entry decoded-instruction queue between fetch and execute.
// Instructions are decoded once on entry; a tag change on either side marks new work.
module cpu_decode_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic [31:0]              i_instruction,
  input  logic [31:0]              i_pc,
  input  logic                     i_flush,
  input  logic                     i_stall,
  output logic                     o_busy,
  output logic [TAG_W-1:0]         o_tag,
  output logic [31:0]              o_instruction,
  output logic [31:0]              o_pc,
  output logic [4:0]               o_inst_rs1,
  output logic [4:0]               o_inst_rs2,
  output logic [4:0]               o_inst_rd,
  output logic [31:0]              o_imm,
  output logic                     o_branch,
  output logic                     o_illegal,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      instruction;
    logic [31:0]      pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic             branch;
    logic             illegal;
  } entry_t;

  fmt_t             fmt;
  entry_t           dec;
  entry_t           mem [DEPTH];
  entry_t           out_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [TAG_W-1:0] last_tag;
  logic             full;
  logic             push;
  logic             pop;

  always_comb begin
    fmt = FMT_BAD;
    if (i_instruction[1:0] == 2'b11) begin
      case (i_instruction[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: fmt = FMT_I;
        7'b0100011:             fmt = FMT_S;
        7'b1100011:             fmt = FMT_B;
        7'b0110111, 7'b0010111: fmt = FMT_U;
        7'b1101111:             fmt = FMT_J;
        7'b0110011:             fmt = FMT_R;
        default:                fmt = FMT_BAD;
      endcase
    end
  end

  // Illegal entries keep instruction and PC but leave every decoded field at zero.
  always_comb begin
    dec             = '0;
    dec.tag         = i_tag;
    dec.instruction = i_instruction;
    dec.pc          = i_pc;
    dec.illegal     = (fmt == FMT_BAD);
    case (fmt)
      FMT_R: begin
        dec.rs1 = i_instruction[19:15];
        dec.rs2 = i_instruction[24:20];
        dec.rd  = i_instruction[11:7];
      end
      FMT_I: begin
        dec.rs1    = i_instruction[19:15];
        dec.rd     = i_instruction[11:7];
        dec.imm    = {{20{i_instruction[31]}}, i_instruction[31:20]};
        dec.branch = (i_instruction[6:0] == 7'b1100111);
      end
      FMT_S: begin
        dec.rs1 = i_instruction[19:15];
        dec.rs2 = i_instruction[24:20];
        dec.imm = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
      end
      FMT_B: begin
        dec.rs1    = i_instruction[19:15];
        dec.rs2    = i_instruction[24:20];
        dec.imm    = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                      i_instruction[30:25], i_instruction[11:8], 1'b0};
        dec.branch = 1'b1;
      end
      FMT_U: begin
        dec.rd  = i_instruction[11:7];
        dec.imm = {i_instruction[31:12], 12'b0};
      end
      FMT_J: begin
        dec.rd     = i_instruction[11:7];
        dec.imm    = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                      i_instruction[20], i_instruction[30:21], 1'b0};
        dec.branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign full = (count == CW'(DEPTH));
  assign push = (i_tag != last_tag) && !full && !i_flush;
  assign pop  = !i_stall && (count != '0) && !i_flush;

  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // Flush drops the queue and the offered tag but leaves the presented entry in place.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_tag <= '0;
      out_q    <= '0;
    end else if (i_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_tag <= i_tag;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        last_tag <= i_tag;
      end
      if (pop) begin
        out_q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_busy        = full;
  assign o_count       = count;
  assign o_tag         = out_q.tag;
  assign o_instruction = out_q.instruction;
  assign o_pc          = out_q.pc;
  assign o_inst_rs1    = out_q.rs1;
  assign o_inst_rs2    = out_q.rs2;
  assign o_inst_rd     = out_q.rd;
  assign o_imm         = out_q.imm;
  assign o_branch      = out_q.branch;
  assign o_illegal     = out_q.illegal;

endmodule

// File: tb/tb_cpu_decode_queue.sv
// Bench for cpu_decode_queue: decode vector table, directed queue corner cases,
// and randomized traffic against a queue-level reference model.
module tb_cpu_decode_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 3;

  logic             i_clock = 1'b0;
  logic             i_reset = 1'b1;
  logic [TAG_W-1:0] i_tag = '0;
  logic [31:0]      i_instruction = '0;
  logic [31:0]      i_pc = '0;
  logic             i_flush = 1'b0;
  logic             i_stall = 1'b0;
  logic             o_busy;
  logic [TAG_W-1:0] o_tag;
  logic [31:0]      o_instruction, o_pc, o_imm;
  logic [4:0]       o_inst_rs1, o_inst_rs2, o_inst_rd;
  logic             o_branch, o_illegal;
  logic [$clog2(DEPTH):0] o_count;

  cpu_decode_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tag(i_tag),
    .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
    .i_stall(i_stall), .o_busy(o_busy), .o_tag(o_tag),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_inst_rs1(o_inst_rs1),
    .o_inst_rs2(o_inst_rs2), .o_inst_rd(o_inst_rd), .o_imm(o_imm),
    .o_branch(o_branch), .o_illegal(o_illegal), .o_count(o_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [4:0]       rs1, rs2, rd;
    logic [31:0]      imm;
    logic             branch, illegal;
  } ent_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        branch, illegal;
  } vec_t;

  ent_t             m_q[$];
  ent_t             m_out;
  logic [TAG_W-1:0] m_last;
  int               checks = 0;
  int               failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference decode built from the format rules with signed integer arithmetic.
  function automatic ent_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    ent_t r;
    byte  f;
    int   si;
    r = '{default: '0};
    r.inst = inst;
    r.pc = pc;
    si = $signed(inst);
    case (inst[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: f = "I";
      7'h23: f = "S";
      7'h63: f = "B";
      7'h37, 7'h17: f = "U";
      7'h6F: f = "J";
      7'h33: f = "R";
      default: f = "X";
    endcase
    if (f == "X") r.illegal = 1'b1;
    if (f inside {"B", "I", "R", "S"}) r.rs1 = inst[19:15];
    if (f inside {"B", "R", "S"}) r.rs2 = inst[24:20];
    if (f inside {"I", "J", "R", "U"}) r.rd = inst[11:7];
    case (f)
      "I": r.imm = si >>> 20;
      "S": r.imm = (si >>> 25) * 32 + int'(inst[11:7]);
      "B": r.imm = (si >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
                   + int'(inst[11:8]) * 2;
      "J": r.imm = (si >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
                   + int'(inst[30:21]) * 2;
      "U": r.imm = inst & 32'hFFFFF000;
      default: r.imm = 0;
    endcase
    r.branch = (inst[6:0] == 7'h63) || (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h67);
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_out = '{default: '0};
    m_last = '0;
  endtask

  task automatic model_edge(input logic [TAG_W-1:0] tag, input logic [31:0] inst,
                            input logic [31:0] pc, input logic flush, input logic stall);
    ent_t e;
    bit   do_push, do_pop;
    if (flush) begin
      m_q.delete();
      m_last = tag;
    end else begin
      do_push = (tag != m_last) && (m_q.size() < DEPTH);
      do_pop  = !stall && (m_q.size() > 0);
      if (do_pop) m_out = m_q.pop_front();
      if (do_push) begin
        e = ref_decode(inst, pc);
        e.tag = tag;
        m_q.push_back(e);
        m_last = tag;
      end
    end
  endtask

  task automatic checkOutput();
    check("tag", o_tag, m_out.tag);
    check("instruction", o_instruction, m_out.inst);
    check("pc", o_pc, m_out.pc);
    check("rs1", o_inst_rs1, m_out.rs1);
    check("rs2", o_inst_rs2, m_out.rs2);
    check("rd", o_inst_rd, m_out.rd);
    check("imm", o_imm, m_out.imm);
    check("branch", o_branch, m_out.branch);
    check("illegal", o_illegal, m_out.illegal);
    check("count", o_count, m_q.size());
    check("busy", o_busy, m_q.size() == DEPTH);
  endtask

  task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic [31:0] inst,
                               input logic [31:0] pc, input logic flush, input logic stall);
    i_tag = tag;
    i_instruction = inst;
    i_pc = pc;
    i_flush = flush;
    i_stall = stall;
    @(posedge i_clock);
    model_edge(tag, inst, pc, flush, stall);
    #1;
    checkOutput();
  endtask

  // Reset is raised mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    i_reset = 1'b1;
    i_tag = '0;
    i_flush = 1'b0;
    i_stall = 1'b0;
    model_reset();
    #1;
    check("reset_tag", o_tag, 0);
    check("reset_count", o_count, 0);
    check("reset_busy", o_busy, 0);
    check("reset_imm", o_imm, 0);
    check("reset_pc", o_pc, 0);
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  vec_t vecs[9];
  logic [6:0] ops[12];

  initial begin
    logic [TAG_W-1:0] prev_tag, t;
    logic [31:0] inst;
    int peak;

    vecs[0] = '{32'hFFF10093, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[1] = '{32'h00208463, 5'd1, 5'd2, 5'd0, 32'h00000008, 1'b1, 1'b0};
    vecs[2] = '{32'h123452B7, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b0, 1'b0};
    vecs[3] = '{32'h00000000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{32'h0000007F, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
    vecs[5] = '{32'h00512623, 5'd2, 5'd5, 5'd0, 32'h0000000C, 1'b0, 1'b0};
    vecs[6] = '{32'hFFDFF0EF, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFC, 1'b1, 1'b0};
    vecs[7] = '{32'h002081B3, 5'd1, 5'd2, 5'd3, 32'h00000000, 1'b0, 1'b0};
    vecs[8] = '{32'h00408067, 5'd1, 5'd0, 5'd0, 32'h00000004, 1'b1, 1'b0};
    ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};

    do_reset();

    // Decode table: each new tag shows up at the output two edges after it is offered.
    prev_tag = '0;
    for (int i = 0; i < 9; i++) begin
      t = TAG_W'((i % 7) + 1);
      applyStimulus(t, vecs[i].inst, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
      check("latency_not_yet", o_tag, prev_tag);
      applyStimulus(t, vecs[i].inst, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
      check("vec_tag", o_tag, t);
      check("vec_pc", o_pc, 32'h1000 + 32'(i * 4));
      check("vec_rs1", o_inst_rs1, vecs[i].rs1);
      check("vec_rs2", o_inst_rs2, vecs[i].rs2);
      check("vec_rd", o_inst_rd, vecs[i].rd);
      check("vec_imm", o_imm, vecs[i].imm);
      check("vec_branch", o_branch, vecs[i].branch);
      check("vec_illegal", o_illegal, vecs[i].illegal);
      prev_tag = t;
    end

    // Fill under stall, then drain in order.
    do_reset();
    for (int k = 1; k <= 4; k++) applyStimulus(TAG_W'(k), 32'h002081B3, 32'(k * 4), 1'b0, 1'b1);
    check("fill_busy", o_busy, 1);
    check("fill_count", o_count, 4);
    applyStimulus(3'd5, 32'h002081B3, 32'd20, 1'b0, 1'b1);
    check("full_held_count", o_count, 4);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(3'd5, 32'h002081B3, 32'd20, 1'b0, 1'b0);
      check("drain_order", o_tag, k);
      if (k == 1) check("busy_falls", o_busy, 0);
    end
    check("drain_empty", o_count, 0);

    // A held tag is pushed only once.
    do_reset();
    peak = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(3'd3, 32'h00512623, 32'h40, 1'b0, 1'b1);
      if (int'(o_count) > peak) peak = int'(o_count);
    end
    check("repeat_peak", peak, 1);
    applyStimulus(3'd3, 32'h00512623, 32'h40, 1'b0, 1'b0);
    check("repeat_tag", o_tag, 3);
    applyStimulus(3'd3, 32'h00512623, 32'h40, 1'b0, 1'b0);
    check("repeat_count", o_count, 0);

    // Flush with three queued entries and a new tag on offer.
    do_reset();
    applyStimulus(3'd1, 32'h002081B3, 32'h04, 1'b0, 1'b0);
    applyStimulus(3'd2, 32'h002081B3, 32'h08, 1'b0, 1'b0);
    applyStimulus(3'd3, 32'h002081B3, 32'h0C, 1'b0, 1'b1);
    applyStimulus(3'd4, 32'h002081B3, 32'h10, 1'b0, 1'b1);
    check("preflush_count", o_count, 3);
    applyStimulus(3'd5, 32'h002081B3, 32'h14, 1'b1, 1'b0);
    check("flush_count", o_count, 0);
    check("flush_tag_hold", o_tag, 1);
    applyStimulus(3'd5, 32'h002081B3, 32'h14, 1'b0, 1'b0);
    check("flush_dropped", o_count, 0);
    applyStimulus(3'd6, 32'h002081B3, 32'h18, 1'b0, 1'b0);
    check("post_flush_wait", o_tag, 1);
    applyStimulus(3'd6, 32'h002081B3, 32'h18, 1'b0, 1'b0);
    check("post_flush_tag", o_tag, 6);

    // Build count=2 with a nonzero presented tag, then reset mid-cycle.
    do_reset();
    applyStimulus(3'd1, 32'h00408067, 32'h04, 1'b0, 1'b0);
    applyStimulus(3'd2, 32'h00408067, 32'h08, 1'b0, 1'b0);
    applyStimulus(3'd3, 32'h00408067, 32'h0C, 1'b0, 1'b1);
    check("prereset_count", o_count, 2);
    check("prereset_tag", o_tag, 1);
    do_reset();

    // Pointer wrap: 2*DEPTH back-to-back pushes and pops.
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      inst = $urandom;
      inst[6:0] = ops[$urandom_range(0, 11)];
      applyStimulus(TAG_W'((i % 7) + 1), inst, 32'(i * 4), 1'b0, 1'b0);
      if (i >= 1) check("wrap_order", o_tag, ((i - 1) % 7) + 1);
    end

    // Randomized traffic against the model.
    t = i_tag;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        t = '0;
      end
      if ($urandom_range(0, 1) == 0) t = TAG_W'($urandom);
      inst = $urandom;
      if ($urandom_range(0, 12) != 12) inst[6:0] = ops[$urandom_range(0, 11)];
      applyStimulus(t, inst, $urandom, $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
